// File: rtl/wb_arbiter_pkg.sv
// Shared register-file geometry and writeback arbiter types.
package wb_arbiter_pkg;

   localparam int unsigned REG_ADDR  = 5;
   localparam int unsigned REG_SIZE  = 32;
   localparam int unsigned REG_N     = 32;
   localparam int unsigned WB_QDEPTH = 4;

   // Source that drives the register file write port on the next edge
   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_PIPE,
      SEL_QUEUE,
      SEL_DROP
   } wb_sel_e;

endpackage

// File: rtl/wb_kill_fifo.sv
// In-order result queue with a per-entry kill bit set by destination-register match.
module wb_kill_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = WB_QDEPTH,
   parameter int unsigned CNT_W = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                push,
   input  logic [REG_ADDR-1:0] push_reg,
   input  logic [REG_SIZE-1:0] push_data,
   input  logic                push_kill,
   input  logic                pop,
   input  logic                kill_en,
   input  logic [REG_ADDR-1:0] kill_reg,
   output logic                head_valid,
   output logic [REG_ADDR-1:0] head_reg,
   output logic [REG_SIZE-1:0] head_data,
   output logic                head_kill,
   output logic [CNT_W-1:0]    count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [REG_ADDR-1:0] mem_reg  [DEPTH];
   logic [REG_SIZE-1:0] mem_data [DEPTH];
   logic [DEPTH-1:0]    mem_kill;
   logic [PTR_W-1:0]    wp, rp;

   assign head_valid = (count != '0);
   assign head_reg   = mem_reg[rp];
   assign head_data  = mem_data[rp];
   assign head_kill  = mem_kill[rp];

   always_ff @(posedge clk) begin
      if (reset) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         mem_kill <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_reg[i]  <= '0;
            mem_data[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill_en && (mem_reg[i] == kill_reg))
               mem_kill[i] <= 1'b1;
         end
         // A push overwrites any stale kill set on the free slot above
         if (push) begin
            mem_reg[wp]  <= push_reg;
            mem_data[wp] <= push_data;
            mem_kill[wp] <= push_kill;
            wp           <= wp + 1'b1;
         end
         if (pop)
            rp <= rp + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline and long-latency results onto the register file write port.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = WB_QDEPTH,
   parameter int unsigned CNT_W = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                p_valid,
   input  logic [REG_ADDR-1:0] p_wreg,
   input  logic [REG_SIZE-1:0] p_wdata,
   input  logic                l_valid,
   output logic                l_ready,
   input  logic [REG_ADDR-1:0] l_wreg,
   input  logic [REG_SIZE-1:0] l_wdata,
   output logic                regwrite,
   output logic [REG_ADDR-1:0] wreg,
   output logic [REG_SIZE-1:0] wdata,
   output logic [CNT_W-1:0]    q_count,
   output logic                idle
);

   logic                p_hit;
   logic                push, push_kill, pop;
   logic                head_valid, head_kill;
   logic [REG_ADDR-1:0] head_reg;
   logic [REG_SIZE-1:0] head_data;
   wb_sel_e             sel;

   assign l_ready   = (q_count < CNT_W'(DEPTH));
   assign p_hit     = p_valid && (p_wreg != '0);
   // r0 results complete the handshake but are never queued
   assign push      = l_valid && l_ready && (l_wreg != '0);
   assign push_kill = p_hit && (p_wreg == l_wreg);
   assign idle      = (q_count == '0) && !regwrite;

   always_comb begin
      sel = SEL_NONE;
      if (p_hit)
         sel = SEL_PIPE;
      else if (head_valid)
         sel = head_kill ? SEL_DROP : SEL_QUEUE;
      pop = (sel == SEL_QUEUE) || (sel == SEL_DROP);
   end

   wb_kill_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_reg   (l_wreg),
      .push_data  (l_wdata),
      .push_kill  (push_kill),
      .pop        (pop),
      .kill_en    (p_hit),
      .kill_reg   (p_wreg),
      .head_valid (head_valid),
      .head_reg   (head_reg),
      .head_data  (head_data),
      .head_kill  (head_kill),
      .count      (q_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         regwrite <= 1'b0;
         wreg     <= '0;
         wdata    <= '0;
      end else begin
         case (sel)
            SEL_PIPE: begin
               regwrite <= 1'b1;
               wreg     <= p_wreg;
               wdata    <= p_wdata;
            end
            SEL_QUEUE: begin
               regwrite <= 1'b1;
               wreg     <= head_reg;
               wdata    <= head_data;
            end
            default: regwrite <= 1'b0;
         endcase
      end
   end

endmodule
